// File: rtl/disp_scan_controller.sv
`default_nettype none
// ============================================================================
// Module      : disp_scan_controller
// Description : Time-multiplexed 7-segment display scanner. Rotates through
//               NUM_DIGITS digits with a blanking interval at the start of
//               every slot, decodes hex nibbles to segments and double-buffers
//               the display data so updates only take effect on frame
//               boundaries.
//               Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses the
//               segments of leading zero digits; digit 0 always displays).
// Revision    : 1.0 - initial release
// ============================================================================
module disp_scan_controller #(
    parameter int NUM_DIGITS       = 4,
    parameter int CLK_HZ           = 27_000_000,
    parameter int SCAN_HZ          = 1000,
    parameter int BLANK_CYCLES     = 270,
    parameter int ANODE_ACTIVE_LOW = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits_i,
    input  logic [NUM_DIGITS-1:0]   dp_i,
    input  logic                    load_i,
    output logic [NUM_DIGITS-1:0]   an_o,
    output logic [6:0]              seg_o,
    output logic                    dp_o,
    output logic                    frame_o
);

    localparam int DWELL = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    // XOR mask applied at the anode register: all ones for active-low boards
    localparam logic [NUM_DIGITS-1:0] AN_IDLE = (ANODE_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                      : {NUM_DIGITS{1'b0}};

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_DRIVE = 1'b1;

    logic [0:0]              state, state_n;
    logic [CNT_W-1:0]        cnt, cnt_n;
    logic [IDX_W-1:0]        idx, idx_n;
    logic                    boundary;
    logic                    frame_n;

    logic [4*NUM_DIGITS-1:0] shadow_dig;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    pending, pending_n;
    logic [4*NUM_DIGITS-1:0] active_dig, active_dig_n;
    logic [NUM_DIGITS-1:0]   active_dp, active_dp_n;

    logic [3:0]              nib_sel;
    logic                    dp_sel;
    logic [NUM_DIGITS-1:0]   an_n;
    logic [6:0]              seg_n;
    logic                    dp_n;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lz_run;
    logic                    lz_hit;
`endif

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0:    hex7 = 7'h3F;
            4'h1:    hex7 = 7'h06;
            4'h2:    hex7 = 7'h5B;
            4'h3:    hex7 = 7'h4F;
            4'h4:    hex7 = 7'h66;
            4'h5:    hex7 = 7'h6D;
            4'h6:    hex7 = 7'h7D;
            4'h7:    hex7 = 7'h07;
            4'h8:    hex7 = 7'h7F;
            4'h9:    hex7 = 7'h6F;
            4'hA:    hex7 = 7'h77;
            4'hB:    hex7 = 7'h7C;
            4'hC:    hex7 = 7'h39;
            4'hD:    hex7 = 7'h5E;
            4'hE:    hex7 = 7'h79;
            default: hex7 = 7'h71;
        endcase
    endfunction

    // The frame boundary is the last driven cycle of the last digit; data
    // swapped here is in place before slot 0 of the next frame begins.
    assign boundary = (state == S_DRIVE) && (cnt == DWELL_LAST) && (idx == IDX_LAST);

    // State register: FSM, slot counter and digit index
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_BLANK;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end
    end

    // Next-state logic: blank for BLANK_CYCLES, drive until slot end, advance digit
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CNT_W'(1);
        idx_n   = idx;
        case (state)
            S_BLANK: begin
                if ((BLANK_CYCLES == 0) || (cnt == BLANK_LAST)) begin
                    state_n = S_DRIVE;
                end
            end
            default: begin
                if (cnt == DWELL_LAST) begin
                    cnt_n   = '0;
                    idx_n   = (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
                    // With no blanking the next slot is driven from its first cycle
                    state_n = (BLANK_CYCLES == 0) ? S_DRIVE : S_BLANK;
                end
            end
        endcase
    end

    // Double-buffer update: loads land in shadow, shadow moves to active at
    // the boundary; a load on the boundary itself bypasses straight to active
    always_comb begin
        active_dig_n = active_dig;
        active_dp_n  = active_dp;
        pending_n    = pending;
        if (boundary) begin
            pending_n = 1'b0;
            if (load_i) begin
                active_dig_n = digits_i;
                active_dp_n  = dp_i;
            end else if (pending) begin
                active_dig_n = shadow_dig;
                active_dp_n  = shadow_dp;
            end
        end else if (load_i) begin
            pending_n = 1'b1;
        end
    end

    // Display data registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_dig <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            active_dig <= '0;
            active_dp  <= '0;
        end else begin
            if (load_i) begin
                shadow_dig <= digits_i;
                shadow_dp  <= dp_i;
            end
            pending    <= pending_n;
            active_dig <= active_dig_n;
            active_dp  <= active_dp_n;
        end
    end

    // Output logic: decode the upcoming cycle so the registered pins line up
    // with the FSM state and index they describe
    always_comb begin
        nib_sel = 4'h0;
        dp_sel  = 1'b0;
        an_n    = '0;
        seg_n   = 7'h00;
        dp_n    = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        lz_run  = 1'b1;
        lz_hit  = 1'b0;
`endif
        // Scan from the most significant digit so lz_run tracks "all zero so far"
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            lz_run = lz_run && (active_dig_n[4*k +: 4] == 4'h0);
`endif
            if (idx_n == IDX_W'(k)) begin
                nib_sel = active_dig_n[4*k +: 4];
                dp_sel  = active_dp_n[k];
                an_n[k] = (state_n == S_DRIVE);
`ifdef LEADING_ZERO_BLANK_EN
                lz_hit  = lz_run && (k != 0);
`endif
            end
        end
        if (state_n == S_DRIVE) begin
            seg_n = hex7(nib_sel);
            dp_n  = dp_sel;
`ifdef LEADING_ZERO_BLANK_EN
            if (lz_hit) begin
                seg_n = 7'h00;
            end
`endif
        end
    end

    // Frame pulse coincides with the boundary cycle
    assign frame_n = (cnt_n == DWELL_LAST) && (idx_n == IDX_LAST);

    // Output registers; anode polarity applied here
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_o    <= AN_IDLE;
            seg_o   <= 7'h00;
            dp_o    <= 1'b0;
            frame_o <= 1'b0;
        end else begin
            an_o    <= an_n ^ AN_IDLE;
            seg_o   <= seg_n;
            dp_o    <= dp_n;
            frame_o <= frame_n;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_disp_scan_controller.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_disp_scan_controller
// Description : Directed self-checking bench for disp_scan_controller with
//               NUM_DIGITS=4, DWELL=10, BLANK_CYCLES=2. Two instances share the
//               stimulus: one with active-high anodes, one active-low.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_disp_scan_controller;

    localparam int N  = 4;
    localparam int DW = 10;
    localparam int BL = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dpi = 4'h0;

    logic [3:0]  an, an_al;
    logic [6:0]  seg, seg_al;
    logic        dp, dp_al, frame, frame_al;
    logic [25:0] obs;
    logic [25:0] exp_v;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    assign obs = {an, seg, dp, frame, an_al, seg_al, dp_al, frame_al};

    always #5 clk = ~clk;

    disp_scan_controller #(
        .NUM_DIGITS(N), .CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(BL), .ANODE_ACTIVE_LOW(0)
    ) dut (
        .clk(clk), .rst(rst), .digits_i(digits), .dp_i(dpi), .load_i(load),
        .an_o(an), .seg_o(seg), .dp_o(dp), .frame_o(frame)
    );

    disp_scan_controller #(
        .NUM_DIGITS(N), .CLK_HZ(100), .SCAN_HZ(10), .BLANK_CYCLES(BL), .ANODE_ACTIVE_LOW(1)
    ) dut_al (
        .clk(clk), .rst(rst), .digits_i(digits), .dp_i(dpi), .load_i(load),
        .an_o(an_al), .seg_o(seg_al), .dp_o(dp_al), .frame_o(frame_al)
    );

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        return t[n];
    endfunction

    // Expected {an,seg,dp,frame} of both instances in cycle c since reset release
    function automatic logic [25:0] model(input int c, input logic [15:0] d, input logic [3:0] p);
        int         slot;
        int         pos;
        logic [3:0] a;
        logic [6:0] s;
        logic       o;
        logic       f;
        slot = (c / DW) % N;
        pos  = c % DW;
        a    = 4'b0000;
        s    = 7'h00;
        o    = 1'b0;
        f    = ((c % (N * DW)) == (N * DW - 1));
        if (pos >= BL) begin
            a[slot] = 1'b1;
            s       = hex7(d[slot*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
            if (slot != 0 && (d >> (slot * 4)) == 16'h0000) s = 7'h00;
`endif
            o = p[slot];
        end
        return {a, s, o, f, ~a, s, o, f};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_v = model(0, 16'h0, 4'h0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_hold got=%h want=%h", obs, exp_v);
        end
        rst = 1'b0;
        cyc = 0;
        exp_v = model(0, 16'h0, 4'h0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL reset_release got=%h want=%h", obs, exp_v);
        end
    endtask

    task automatic test_scan;
        while (cyc < 80) begin
            exp_v = model(cyc, 16'h0, 4'h0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL scan cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_load_midframe;
        while (cyc < 159) begin
            exp_v = (cyc < 120) ? model(cyc, 16'h0, 4'h0) : model(cyc, 16'h1A3F, 4'b0100);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_midframe cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            load = 1'b0;
            if (cyc == 85) begin
                load   = 1'b1;
                digits = 16'h1A3F;
                dpi    = 4'b0100;
            end else if (cyc == 86) begin
                digits = 16'hFFFF;
                dpi    = 4'b1111;
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_load_on_boundary;
        exp_v = model(cyc, 16'h1A3F, 4'b0100);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL boundary_frame cyc=%0d got=%h want=%h", cyc, obs, exp_v);
        end
        load   = 1'b1;
        digits = 16'h0008;
        dpi    = 4'b0000;
        tick();
        load   = 1'b0;
        digits = 16'hFFFF;
        dpi    = 4'b1111;
        while (cyc < 240) begin
            exp_v = model(cyc, 16'h0008, 4'h0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL load_on_boundary cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back;
        while (cyc < 320) begin
            exp_v = (cyc < 280) ? model(cyc, 16'h0008, 4'h0) : model(cyc, 16'h0050, 4'b0001);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL back_to_back cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            load = 1'b0;
            if (cyc == 245) begin
                load   = 1'b1;
                digits = 16'h1111;
                dpi    = 4'b1111;
            end else if (cyc == 250) begin
                load   = 1'b1;
                digits = 16'h0050;
                dpi    = 4'b0001;
            end
            tick();
        end
        load = 1'b0;
    endtask

    task automatic test_async_reset;
        while (cyc <= 325) begin
            exp_v = model(cyc, 16'h0050, 4'b0001);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL pre_reset cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            if (cyc < 325) tick();
            else break;
        end
        #2;
        rst = 1'b1;
        #1;
        exp_v = model(0, 16'h0, 4'h0);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL async_reset got=%h want=%h", obs, exp_v);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        while (cyc < 80) begin
            exp_v = model(cyc, 16'h0, 4'h0);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL post_reset cyc=%0d got=%h want=%h", cyc, obs, exp_v);
            end
            tick();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_scan();
        test_load_midframe();
        test_load_on_boundary();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/disp_scan_controller.md
# disp_scan_controller

Parametrised time-multiplexed 7-segment display driver that supersedes the fixed 3-digit anode rotator. It scans NUM_DIGITS common-anode/cathode digits at a configurable per-digit dwell and inserts an anti-ghosting blanking interval at the start of each slot. It also decodes hex nibbles to segments and double-buffers display data, so updates never tear mid-frame. It sits between the datapath's display registers and the board's digit/segment pins.

## Interface
- NUM_DIGITS, 4, number of scanned digits (2..8)
- CLK_HZ, 27_000_000, input clock frequency in Hz
- SCAN_HZ, 1000, digit slot rate; DWELL = CLK_HZ/SCAN_HZ cycles per digit (must be ≥ 2)
- BLANK_CYCLES, 270, cycles at the start of each slot with all anodes off (must be < DWELL; 0 allowed)
- ANODE_ACTIVE_LOW, 0, 1 = an_o digit enable is driven low
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- digits_i  in  4*NUM_DIGITS  hex nibbles; nibble k = digit k, digit 0 is rightmost
- dp_i  in  NUM_DIGITS  decimal-point request per digit
- load_i  in  1  single-cycle strobe capturing digits_i/dp_i
- an_o  out  NUM_DIGITS  digit enables, one-hot active or all inactive
- seg_o  out  7  {g,f,e,d,c,b,a}, active-high
- dp_o  out  1  decimal point, active-high
- frame_o  out  1  one-cycle pulse on each frame boundary

## Operation
- Registers: shadow (digits, dp, pending flag), active (digits, dp), slot counter cnt (width $clog2(DWELL)), digit index idx, and a 2-state FSM.
- FSM BLANK: an_o all inactive, seg_o=0, dp_o=0. Transition to DRIVE when cnt == BLANK_CYCLES-1 (or immediately when BLANK_CYCLES=0).
- FSM DRIVE: an_o bit idx active; seg_o = hex decode of active nibble idx; dp_o = active dp[idx]. At cnt == DWELL-1, go to BLANK, cnt←0, and idx←idx+1, wrapping N-1→0.
- Hex decode, gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Frame boundary is the cycle where idx wraps N-1→0. On that cycle frame_o=1, and if pending then active←shadow and pending←0.
- load_i: shadow←{digits_i,dp_i}, pending←1. If load_i coincides with a boundary, the newly loaded data becomes active at that same boundary (bypass) and pending stays 0.
- Multiple loads within one frame: the last one wins.
- an_o polarity is inverted at the output register when ANODE_ACTIVE_LOW=1. At most one digit is active in any cycle.

## Timing
- Reset (async assert, synchronous release on the next clk edge): cnt=0, idx=0, FSM=BLANK, all an_o inactive (all 1s if ANODE_ACTIVE_LOW), seg_o=0, dp_o=0, frame_o=0, shadow=0, active=0, pending=0.
- Reset asserted mid-slot forces all anodes inactive in the same instant (asynchronous); no partial slot resumes.
- All outputs are registered. an_o/seg_o/dp_o change on the clk edge where the FSM state or idx changes.
- Per slot: BLANK_CYCLES inactive cycles, then DWELL-BLANK_CYCLES driven cycles. Frame period = NUM_DIGITS*DWELL cycles.
- Load-to-display latency: at most one frame plus one slot of blanking.
- First frame after reset: frame_o first pulses NUM_DIGITS*DWELL cycles after reset release, then every frame period.

## Configuration
- LEADING_ZERO_BLANK_EN defined: during DRIVE, digit idx shows seg_o=0 when all nibbles from NUM_DIGITS-1 down to idx are zero and idx≠0. Digit 0 always displays. The anode is still driven and dp_o still follows dp[idx].
- Undefined: every digit shows its decoded nibble, including leading zeros.

## Test plan
- Params NUM_DIGITS=4, CLK_HZ=100, SCAN_HZ=10, BLANK_CYCLES=2; reset then idle -> an_o=0000 for 2 cycles, then 0001 for 8 cycles, then 0000 for 2 cycles, then 0010; frame_o pulses every 40 cycles.
- load_i with digits_i=16'h1A3F, dp_i=4'b0100 mid-frame -> no change until the next frame_o; then slots show seg 71,4F,77,06 and dp_o=1 only in slot 2.
- load_i asserted exactly on the frame_o cycle with 16'h0008 -> new data is displayed starting in that frame's slot 0 (seg 7F).
- Assert rst during a DRIVE slot -> an_o goes inactive immediately; after release the slot sequence restarts at idx 0 and active data is 0 (seg 3F).
- ANODE_ACTIVE_LOW=1 -> an_o=1111 in BLANK and 1110 in DRIVE for slot 0; an_o never has more than one bit low.
- With LEADING_ZERO_BLANK_EN defined, load 16'h0050 -> digits 3 and 2 give seg 00, digit 1 gives 6D, digit 0 gives 3F; without the macro, digits 3 and 2 give 3F.
